pe_conv_sequencer: RTL

- Control sequencer for one PE's convolution pass.
- Latches a layer configuration on start, then paces the buffer input stream through a valid/ready handshake. Phases: line-buffer clear, filter load, bias load, feature-map streaming.
- Generates all per-channel shifting, mac and enable strobes for the PE, plus a latency-matched out_valid, busy and done.
- Sits between the buffer read controller and the PE datapath; one instance per PE.

---
 rtl/pe_conv_sequencer_if.sv | 49 ++++
 rtl/pe_conv_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pe_conv_sequencer_if.sv
// Handshake and strobe bundle between the buffer read controller, the
// convolution sequencer and the PE datapath.
interface pe_conv_sequencer_if #(
    parameter int N_CH   = 32,
    parameter int ADDR_W = 10
);
    // Configuration and pass request
    logic              start;
    logic [ADDR_W-1:0] row_length;
    logic [ADDR_W-1:0] num_rows;
    logic [N_CH-1:0]   ch_mask;
    logic              bias_cfg;
    logic              nl_cfg;
    logic              fb_cfg;

    // Buffer input stream handshake
    logic              in_valid;
    logic              in_ready;

    // PE datapath strobes and status
    logic [N_CH-1:0]   shifting_line;
    logic [N_CH-1:0]   shifting_filter;
    logic              shifting_bias;
    logic [N_CH-1:0]   mac_enable;
    logic              bias_enable;
    logic              nl_enable;
    logic              feedback_enable;
    logic              line_buffer_reset;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              cfg_err;

    // Upstream side: issues passes and presents buffer words
    modport master (
        output start, row_length, num_rows, ch_mask, bias_cfg, nl_cfg, fb_cfg, in_valid,
        input  in_ready, shifting_line, shifting_filter, shifting_bias, mac_enable,
               bias_enable, nl_enable, feedback_enable, line_buffer_reset, out_valid,
               busy, done, cfg_err
    );

    // Sequencer side
    modport slave (
        input  start, row_length, num_rows, ch_mask, bias_cfg, nl_cfg, fb_cfg, in_valid,
        output in_ready, shifting_line, shifting_filter, shifting_bias, mac_enable,
               bias_enable, nl_enable, feedback_enable, line_buffer_reset, out_valid,
               busy, done, cfg_err
    );
endinterface

// File: rtl/pe_conv_sequencer.sv
// Per-PE convolution pass sequencer: clears line buffers, loads filter and
// bias, streams the feature map and issues latency-matched out_valid.
module pe_conv_sequencer #(
    parameter int N_CH     = 32,
    parameter int ADDR_W   = 10,
    parameter int K        = 3,
    parameter int PIPE_LAT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_conv_sequencer_if.slave   bus
);
    localparam logic [ADDR_W-1:0] KW    = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] KM1   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] KK_M1 = ADDR_W'(K * K - 1);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {StIdle, StClr, StFlt, StBias, StFeat, StDrain} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   row_len_q;
    logic [ADDR_W-1:0]   num_rows_q;
    logic [N_CH-1:0]     ch_mask_q;
    logic [ADDR_W-1:0]   flt_cnt_q;
    logic [ADDR_W-1:0]   col_q;
    logic [ADDR_W-1:0]   row_q;
    logic                in_ready_q;
    logic                lbr_q;
    logic                busy_q;
    logic                done_q;
    logic                cfg_err_q;
    logic                bias_en_q;
    logic                nl_en_q;
    logic                fb_en_q;
    logic [PIPE_LAT-1:0] pipe_q;

    logic beat;
    logic flt_beat;
    logic bias_beat;
    logic feat_beat;
    logic win_done;
    logic mac_issue;
    logic col_last;
    logic row_last;
    logic cfg_bad;

    // Beat qualification and window detection; strobes follow in_valid in the same cycle
    always_comb begin
        beat      = bus.in_valid & in_ready_q;
        flt_beat  = beat & (state_q == StFlt);
        bias_beat = beat & (state_q == StBias);
        feat_beat = beat & (state_q == StFeat);
        win_done  = (row_q >= KM1) && (col_q >= KM1);
        mac_issue = feat_beat & win_done & (|ch_mask_q);
        col_last  = (col_q == row_len_q - ONE);
        row_last  = (row_q == num_rows_q - ONE);
        cfg_bad   = (bus.row_length < KW) || (bus.num_rows < KW);
    end

    // Pass FSM with registered control outputs and stream counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            row_len_q  <= '0;
            num_rows_q <= '0;
            ch_mask_q  <= '0;
            flt_cnt_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            in_ready_q <= 1'b0;
            lbr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            bias_en_q  <= 1'b0;
            nl_en_q    <= 1'b0;
            fb_en_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            lbr_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            row_len_q  <= bus.row_length;
                            num_rows_q <= bus.num_rows;
                            ch_mask_q  <= bus.ch_mask;
                            bias_en_q  <= bus.bias_cfg;
                            nl_en_q    <= bus.nl_cfg;
                            fb_en_q    <= bus.fb_cfg;
                            busy_q     <= 1'b1;
                            lbr_q      <= 1'b1;
                            state_q    <= StClr;
                        end
                    end
                end
                StClr: begin
                    flt_cnt_q  <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= StFlt;
                end
                StFlt: begin
                    if (beat) begin
                        if (flt_cnt_q == KK_M1) begin
                            flt_cnt_q <= '0;
                            state_q   <= StBias;
                        end else begin
                            flt_cnt_q <= flt_cnt_q + ONE;
                        end
                    end
                end
                StBias: begin
                    // The bias word is consumed even when bias is not applied
                    if (beat) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= StFeat;
                    end
                end
                StFeat: begin
                    if (beat) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                in_ready_q <= 1'b0;
                                state_q    <= StDrain;
                            end else begin
                                row_q <= row_q + ONE;
                            end
                        end else begin
                            col_q <= col_q + ONE;
                        end
                    end
                end
                StDrain: begin
                    // Finish only once every issued MAC has produced its output
                    if (pipe_q == '0) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        bias_en_q <= 1'b0;
                        nl_en_q   <= 1'b0;
                        fb_en_q   <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Latency pipe tracks the free-running PE pipeline, so it shifts through stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pipe_q[0] <= mac_issue;
        end
    end

    assign bus.in_ready          = in_ready_q;
    assign bus.shifting_filter   = flt_beat ? ch_mask_q : '0;
    assign bus.shifting_bias     = bias_beat;
    assign bus.shifting_line     = feat_beat ? ch_mask_q : '0;
    assign bus.mac_enable        = (feat_beat & win_done) ? ch_mask_q : '0;
    assign bus.bias_enable       = bias_en_q;
    assign bus.nl_enable         = nl_en_q;
    assign bus.feedback_enable   = fb_en_q;
    assign bus.line_buffer_reset = lbr_q;
    assign bus.out_valid         = pipe_q[PIPE_LAT-1];
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.cfg_err           = cfg_err_q;
endmodule
